// File: rtl/cpu_pkg.sv
// Shared types and default phase constants for the multi-cycle CPU control.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } cpu_state_e;

    localparam int PHASES_DEF      = 8;
    localparam int ALU_PHASE_DEF   = 1;
    localparam int FETCH_START_DEF = 3;
    localparam int FETCH_END_DEF   = 6;

endpackage

// File: rtl/cpu_phase_win.sv
// Window comparator: flags a phase index lying inside [lo, hi] inclusive.
// Latency: purely combinational.
// Backpressure: none.
module cpu_phase_win #(
    parameter int W = 3
) (
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] phase,
    output logic         in_window
);

    assign in_window = (phase >= lo) && (phase <= hi);

endmodule

// File: rtl/cpu_phase_gen.sv
// Instruction-cycle phase generator with stall freeze, graceful stop, single-step and cycle counter.
// Latency: all outputs registered; they equal the decode of the state/phase held in the same flops.
// Backpressure: stall freezes the whole generator while ACTIVE; ignored in IDLE and PAUSE.
module cpu_phase_gen
    import cpu_pkg::*;
#(
    parameter int PHASES      = PHASES_DEF,
    parameter int ALU_PHASE   = ALU_PHASE_DEF,
    parameter int FETCH_START = FETCH_START_DEF,
    parameter int FETCH_END   = FETCH_END_DEF,
    parameter int CNT_W       = 16,
    localparam int PW         = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stall,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             fetch,
    output logic             alu_ena,
    output logic [PW-1:0]    phase,
    output logic             cycle_start,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);

    // Refuse to elaborate with parameters that would make the windows meaningless.
    if (PHASES < 2) begin : g_chk_phases
        $error("cpu_phase_gen: PHASES must be >= 2");
    end
    if (ALU_PHASE < 0 || ALU_PHASE >= PHASES) begin : g_chk_alu
        $error("cpu_phase_gen: ALU_PHASE must be in [0, PHASES)");
    end
    if (FETCH_START < 0 || FETCH_START > FETCH_END || FETCH_END >= PHASES) begin : g_chk_fetch
        $error("cpu_phase_gen: need 0 <= FETCH_START <= FETCH_END < PHASES");
    end
    if (CNT_W < 1) begin : g_chk_cnt
        $error("cpu_phase_gen: CNT_W must be >= 1");
    end

    cpu_state_e       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             fetch_q, fetch_d;
    logic             alu_ena_q, alu_ena_d;
    logic             cycle_start_q, cycle_start_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             enter_p0;
    logic             fetch_win;
    logic             alu_win;

    // Windows are evaluated on the next phase so the registered enables line up with phase_q.
    cpu_phase_win #(.W(PW)) u_fetch_win (
        .lo        (PW'(FETCH_START)),
        .hi        (PW'(FETCH_END)),
        .phase     (phase_d),
        .in_window (fetch_win)
    );

    cpu_phase_win #(.W(PW)) u_alu_win (
        .lo        (PW'(ALU_PHASE)),
        .hi        (PW'(ALU_PHASE)),
        .phase     (phase_d),
        .in_window (alu_win)
    );

    // Next state/phase: a started instruction cycle always runs to its last phase.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        enter_p0 = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d  = ST_ACTIVE;
                    phase_d  = '0;
                    enter_p0 = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!stall) begin
                    if (phase_q == LAST_PH) begin
                        phase_d = '0;
                        if (!run) begin
                            state_d = ST_IDLE;
                        end else if (step_mode) begin
                            state_d = ST_PAUSE;
                        end else begin
                            enter_p0 = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            ST_PAUSE: begin
                // A step request outranks a concurrent stop.
                if (step_req) begin
                    state_d  = ST_ACTIVE;
                    phase_d  = '0;
                    enter_p0 = 1'b1;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Output decode of the next state; a stalled ACTIVE state decodes to the same values, so outputs hold.
    always_comb begin
        fetch_d       = (state_d == ST_ACTIVE) && fetch_win;
        alu_ena_d     = (state_d == ST_ACTIVE) && alu_win;
        cycle_start_d = (state_d == ST_ACTIVE) && (phase_d == '0);
        halted_d      = (state_d != ST_ACTIVE);
        cycle_cnt_d   = enter_p0 ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
    end

    // State and output registers; reset wins over stall and aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            fetch_q       <= 1'b0;
            alu_ena_q     <= 1'b0;
            cycle_start_q <= 1'b0;
            halted_q      <= 1'b1;
            cycle_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            fetch_q       <= fetch_d;
            alu_ena_q     <= alu_ena_d;
            cycle_start_q <= cycle_start_d;
            halted_q      <= halted_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end

    assign fetch       = fetch_q;
    assign alu_ena     = alu_ena_q;
    assign phase       = phase_q;
    assign cycle_start = cycle_start_q;
    assign halted      = halted_q;
    assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_phase_gen.sv
module tb_cpu_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, run, stall, step_mode, step_req;

    // Instance 1: default parameters.
    logic        f1, a1, cs1, h1;
    logic [2:0]  p1;
    logic [15:0] c1;
    // Instance 2: 5-phase cycle, alu at 0, fetch at 4 only, 4-bit counter.
    logic        f2, a2, cs2, h2;
    logic [2:0]  p2;
    logic [3:0]  c2;

    cpu_phase_gen dut1 (
        .clk(clk), .reset(reset), .run(run), .stall(stall),
        .step_mode(step_mode), .step_req(step_req),
        .fetch(f1), .alu_ena(a1), .phase(p1), .cycle_start(cs1),
        .halted(h1), .cycle_cnt(c1)
    );

    cpu_phase_gen #(
        .PHASES(5), .ALU_PHASE(0), .FETCH_START(4), .FETCH_END(4), .CNT_W(4)
    ) dut2 (
        .clk(clk), .reset(reset), .run(run), .stall(stall),
        .step_mode(step_mode), .step_req(step_req),
        .fetch(f2), .alu_ena(a2), .phase(p2), .cycle_start(cs2),
        .halted(h2), .cycle_cnt(c2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle, 1=running an instruction cycle, 2=paused.
    typedef struct {
        int mode;
        int pos;
        int cnt;
    } mdl_t;

    mdl_t m1, m2;
    bit   mvalid = 1'b0;

    function automatic mdl_t advance(mdl_t m, int nph, int cw);
        mdl_t n = m;
        bit   newcyc = 1'b0;
        if (m.mode == 0) begin
            if (run) newcyc = 1'b1;
        end else if (m.mode == 1) begin
            if (!stall) begin
                if (m.pos + 1 < nph) n.pos = m.pos + 1;
                else if (!run)       begin n.mode = 0; n.pos = 0; end
                else if (step_mode)  begin n.mode = 2; n.pos = 0; end
                else                 newcyc = 1'b1;
            end
        end else begin
            if (step_req)  newcyc = 1'b1;
            else if (!run) n.mode = 0;
        end
        if (newcyc) begin
            n.mode = 1;
            n.pos  = 0;
            n.cnt  = (m.cnt + 1) % (1 << cw);
        end
        return n;
    endfunction

    // Model advances on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        if (reset) begin
            m1     <= '{0, 0, 0};
            m2     <= '{0, 0, 0};
            mvalid <= 1'b1;
        end else if (mvalid) begin
            m1 <= advance(m1, 8, 16);
            m2 <= advance(m2, 5, 4);
        end
    end

    task automatic cmp_all(input string tag, input mdl_t m, input int alu_ph,
                           input int flo, input int fhi,
                           input logic f, input logic a, input logic [2:0] p,
                           input logic cs, input logic h, input logic [31:0] c);
        bit on;
        on = (m.mode == 1);
        check({tag, "_phase"},  p,  on ? m.pos : 0);
        check({tag, "_fetch"},  f,  on && m.pos >= flo && m.pos <= fhi);
        check({tag, "_alu"},    a,  on && m.pos == alu_ph);
        check({tag, "_cstart"}, cs, on && m.pos == 0);
        check({tag, "_halted"}, h,  !on);
        check({tag, "_cnt"},    c,  m.cnt);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            cmp_all("m1", m1, 1, 3, 6, f1, a1, p1, cs1, h1, 32'(c1));
            cmp_all("m2", m2, 0, 4, 4, f2, a2, p2, cs2, h2, 32'(c2));
        end
    end

    task automatic wait_p1(input int ph);
        int i = 0;
        while (p1 !== 3'(ph) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("wait_p1", p1, ph);
    endtask

    task automatic wait_p2(input int ph);
        int i = 0;
        while (p2 !== 3'(ph) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("wait_p2", p2, ph);
    endtask

    int saved;

    initial begin
        reset = 1'b1; run = 1'b1; stall = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_halted", h1, 1);
        check("rst_phase", p1, 0);
        check("rst_cnt", c1, 0);
        check("rst_cstart", cs1, 0);
        reset = 1'b0;

        // Free running with defaults: clock k after reset release.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("seq_phase", p1, (k - 1) % 8);
            check("seq_alu", a1, ((k - 1) % 8) == 1);
            check("seq_fetch", f1, ((k - 1) % 8) >= 3 && ((k - 1) % 8) <= 6);
            if (k == 1) begin
                check("seq_cs1", cs1, 1);
                check("seq_cnt1", c1, 1);
            end
            if (k == 9) check("seq_cnt9", c1, 2);
        end

        // Stall for three clocks at phase 4.
        wait_p1(4);
        saved = c1;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_phase", p1, 4);
            check("stall_fetch", f1, 1);
            check("stall_cnt", c1, saved);
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_phase", p1, 5);

        // Graceful stop requested at phase 2.
        wait_p1(2);
        run = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            check("stop_phase", p1, k);
        end
        @(negedge clk);
        check("stop_halted", h1, 1);
        check("stop_phase0", p1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stop_noalu", a1, 0);
        end

        // Single-step mode.
        step_mode = 1'b1;
        run = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            check("sm_phase", p1, k);
        end
        @(negedge clk);
        check("sm_paused", h1, 1);
        saved = c1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("pause_halted", h1, 1);
            check("pause_phase", p1, 0);
        end
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("step_cnt", c1, saved + 1);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) @(negedge clk);
            check("step_phase", p1, k);
            check("step_active", h1, 0);
        end
        @(negedge clk);
        check("step_repaused", h1, 1);
        check("step_cnt_after", c1, saved + 1);
        // step_req beats run=0 in the same cycle.
        run = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("step_vs_stop", h1, 0);
        step_mode = 1'b0;

        // Short-cycle instance: period, windows, counter wrap.
        reset = 1'b1;
        run = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 76; k++) begin
            @(negedge clk);
            check("p5_phase", p2, (k - 1) % 5);
            check("p5_alu", a2, ((k - 1) % 5) == 0);
            check("p5_fetch", f2, ((k - 1) % 5) == 4);
            if (k == 71) check("wrap_cnt15", c2, 15);
            if (k == 76) check("wrap_cnt0", c2, 0);
        end
        wait_p2(3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_fetch", f2, 0);
        check("abort_alu", a2, 0);
        check("abort_phase", p2, 0);
        check("abort_cstart", cs2, 0);
        check("abort_halted", h2, 1);
        check("abort_cnt", c2, 0);
        reset = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset    = ($urandom % 300) == 0;
            run      = ($urandom % 10) != 0;
            stall    = ($urandom % 5) == 0;
            step_req = ($urandom % 8) == 0;
            if (($urandom % 50) == 0) step_mode = ~step_mode;
        end
        reset = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
